periph_timer_irq: RTL
=====================

# periph_timer_irq

Memory-mapped timer and interrupt-aggregation peripheral on the processor/peripheral bus, acting as the responder to the processor's accesses. It decodes `address`/`data_we`, accepts zero-wait-state writes, and answers reads with a configurable number of `stall_sig` wait states. It runs a 32-bit compare timer, latches edges on the eight `ext_orq` request lines, and drives masked pending interrupts onto `ext_irq`.

## Interface
- `BASE_ADDR`, default 32'hE100_0000 — block base; 32-byte window, `address[31:5]` must match `BASE_ADDR[31:5]`
- `WAIT_STATES`, default 1 — read stall cycles, legal 1..3
- `clock_in`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `address`  in  32  byte address from processor
- `data_write`  in  32  write data
- `data_we`  in  4  byte write enables; 4'b0000 with in-window address = read
- `data_read`  out  32  read data, valid only in DONE cycle, else 0
- `stall_sig`  out  1  high while a read is in WAIT
- `ext_orq`  in  8  external request lines, rising-edge sensitive
- `ext_irq`  out  8  interrupt lines to processor = `pending & mask`

## Operation
- Register map (offset = `address[4:2]`):
  - 0 COUNTER (RW, byte-writable)
  - 1 COMPARE (RW)
  - 2 CTRL (RW): bit0 enable, bits 15:8 irq mask, others read 0
  - 3 PENDING (bits 7:0; write-1-to-clear per bit)
  - 4 ORQ (RO, synchronized `ext_orq` value)
  - 5–7 read 0, writes ignored
- Counter increments by 1 every cycle while enable=1; wraps 32'hFFFF_FFFF→0 silently.
- Match: enable=1 and COUNTER==COMPARE sets pending[0].
- `ext_orq` sampled through one register stage; a 0→1 on sampled bit n (n=1..7) sets pending[n]. `ext_orq[0]` is readable in ORQ only.
- Read FSM:
  - IDLE: in-window read → WAIT.
  - WAIT: `stall_sig`=1; stays WAIT_STATES cycles → DONE.
  - DONE: `stall_sig`=0; `data_read`=register value captured on DONE entry → IDLE.
- Writes accepted only in IDLE, applied at the clock edge of the cycle presented; `data_we` bytes honored individually.
- Out-of-window accesses: no effect, `stall_sig`=0, `data_read`=0.
- Priorities:
  - Write to COUNTER beats increment.
  - Set (match/edge) beats W1C clear of the same bit.
  - Write to CTRL/COMPARE takes effect from the next cycle's match evaluation.

## Timing
- Reset values: all registers 0, FSM IDLE, `stall_sig`=0, `data_read`=0, `ext_irq`=0, orq sample register 0.
- Reset mid-read drops the access; outputs take reset values next cycle.
- Read latency: address at cycle t → `stall_sig` high t+1..t+WAIT_STATES → data at t+WAIT_STATES+1.
- A read held in-window during DONE starts a new access in the following IDLE cycle.
- Match and `ext_irq` timing:
  - Match sets pending on the edge after COUNTER==COMPARE.
  - `ext_irq` is registered and rises one cycle after pending sets.
  - W1C drops `ext_irq` one cycle after the write.
- `ext_orq` edge → pending set 2 cycles later → `ext_irq` 3 cycles later.

## Configuration
- `PERIPH_TIMER_AUTORELOAD_EN`:
  - Defined: on a match cycle the counter loads 0 instead of incrementing, giving a period of COMPARE+1 cycles.
  - Undefined: counter free-runs and wraps; a match recurs every 2^32 cycles.

## Test plan
- Reset, then read CTRL with WAIT_STATES=1 → `stall_sig` high exactly 1 cycle, `data_read`=0 in DONE.
- Write COMPARE=10, mask=8'h01, enable=1 → pending[0] set 11 cycles after enable; `ext_irq[0]`=1 one cycle later; W1C 32'h1 to PENDING clears it.
- With `PERIPH_TIMER_AUTORELOAD_EN`, COMPARE=4 → `ext_irq[0]` re-asserts every 5 cycles after each W1C; without the macro, COUNTER reads 5, 6, … past the match.
- Pulse `ext_orq[3]` 0→1, mask=8'h08 → `ext_irq[3]`=1 three cycles later; hold `ext_orq[3]` high → no re-set after clear.
- Write COUNTER=32'hFFFF_FFFE with `data_we`=4'b0011, prior value 0 → COUNTER=32'h0000_FFFE; write 32'hFFFF_FFFF, enable → wraps to 0, no irq with COMPARE=5.
- Same cycle: match on bit0 plus W1C of bit0 → pending[0] stays 1; reset asserted during WAIT → `stall_sig`=0 next cycle.

Source files
------------

// File: rtl/periph_timer_irq.sv
// periph_timer_irq
//   Memory-mapped compare timer and interrupt aggregator. It is the responder
//   on the processor/peripheral bus. Writes complete with no wait states.
//   Reads stall for WAIT_STATES cycles and then return data.
//
//   Compile option:
//     PERIPH_TIMER_AUTORELOAD_EN : on a match cycle the counter reloads to 0,
//                                  so the period is COMPARE+1 cycles.
//                                  Without it the counter free-runs and wraps.
//
//   Ports:
//     clock_in    sole clock, rising edge
//     reset       synchronous, active-high
//     address     byte address; the 32-byte window is selected by [31:5]
//     data_write  write data
//     data_we     byte write enables; 4'b0000 at an in-window address = read
//     data_read   read data; valid only in the DONE cycle, 0 otherwise
//     stall_sig   high while a read waits
//     ext_orq     external request lines, rising-edge sensitive
//     ext_irq     registered (pending & mask)
//
//   Register map (offset = address[4:2]):
//     0 COUNTER, 1 COMPARE, 2 CTRL {mask[15:8], enable[0]},
//     3 PENDING (write 1 to clear), 4 ORQ (read-only), 5-7 reserved
module periph_timer_irq #(
  parameter logic [31:0] BASE_ADDR   = 32'hE100_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_write,
  input  logic [3:0]  data_we,
  output logic [31:0] data_read,
  output logic        stall_sig,
  input  logic [7:0]  ext_orq,
  output logic [7:0]  ext_irq
);

`ifdef PERIPH_TIMER_AUTORELOAD_EN
  localparam logic AUTORELOAD = 1'b1;
`else
  localparam logic AUTORELOAD = 1'b0;
`endif

  localparam logic [1:0] WS = WAIT_STATES[1:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [2:0]  rd_off_q, rd_off_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] counter_q, counter_d;
  logic [31:0] compare_q, compare_d;
  logic        enable_q, enable_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  orq_q;
  logic [7:1]  orq_prev_q;
  logic [7:0]  irq_q;

  logic        in_win, wr_en, rd_start, match;
  logic [2:0]  off;
  logic [7:0]  clr;
  logic [31:0] ctrl_val, ctrl_new, reg_rdata;

  // Address bits [1:0] are not decoded: only word accesses are meaningful.
  logic unused_addr;
  assign unused_addr = ^address[1:0];

  function automatic logic [31:0] bmerge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  assign in_win   = (address[31:5] == BASE_ADDR[31:5]);
  assign off      = address[4:2];
  assign wr_en    = in_win && (state_q == S_IDLE) && (data_we != 4'b0000);
  assign rd_start = in_win && (state_q == S_IDLE) && (data_we == 4'b0000);
  assign match    = enable_q && (counter_q == compare_q);
  assign ctrl_val = {16'h0, mask_q, 7'h0, enable_q};
  assign ctrl_new = bmerge(ctrl_val, data_write, data_we);

  // Read mux uses the offset latched when the access started, so the
  // processor may move the address while the read is stalled.
  always_comb begin
    reg_rdata = 32'h0;
    case (rd_off_q)
      3'd0:    reg_rdata = counter_q;
      3'd1:    reg_rdata = compare_q;
      3'd2:    reg_rdata = ctrl_val;
      3'd3:    reg_rdata = {24'h0, pending_q};
      3'd4:    reg_rdata = {24'h0, orq_q};
      default: reg_rdata = 32'h0;
    endcase
  end

  // Read FSM
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rd_off_d = rd_off_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (rd_start) begin
        state_d  = S_WAIT;
        wcnt_d   = 2'd1;
        rd_off_d = off;
      end
      S_WAIT: if (wcnt_q == WS) begin
        state_d = S_DONE;
        rdata_d = reg_rdata;
      end else begin
        wcnt_d = wcnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer and interrupt datapath
  always_comb begin
    counter_d = counter_q;
    compare_d = compare_q;
    enable_d  = enable_q;
    mask_d    = mask_q;
    clr       = 8'h0;

    // A counter write takes priority over both increment and reload.
    if (wr_en && off == 3'd0)
      counter_d = bmerge(counter_q, data_write, data_we);
    else if (enable_q)
      counter_d = (AUTORELOAD && match) ? 32'h0 : counter_q + 32'd1;

    if (wr_en && off == 3'd1)
      compare_d = bmerge(compare_q, data_write, data_we);

    if (wr_en && off == 3'd2) begin
      enable_d = ctrl_new[0];
      mask_d   = ctrl_new[15:8];
    end

    if (wr_en && off == 3'd3 && data_we[0])
      clr = data_write[7:0];

    // The set term is ORed in after the clear, so a new event wins over
    // a write-1-to-clear of the same bit in the same cycle.
    pending_d = (pending_q & ~clr) | {orq_q[7:1] & ~orq_prev_q, match};
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 2'd0;
      rd_off_q   <= 3'd0;
      rdata_q    <= 32'h0;
      counter_q  <= 32'h0;
      compare_q  <= 32'h0;
      enable_q   <= 1'b0;
      mask_q     <= 8'h0;
      pending_q  <= 8'h0;
      orq_q      <= 8'h0;
      orq_prev_q <= 7'h0;
      irq_q      <= 8'h0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rd_off_q   <= rd_off_d;
      rdata_q    <= rdata_d;
      counter_q  <= counter_d;
      compare_q  <= compare_d;
      enable_q   <= enable_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      orq_q      <= ext_orq;
      orq_prev_q <= orq_q[7:1];
      irq_q      <= pending_q & mask_q;
    end
  end

  assign stall_sig = (state_q == S_WAIT);
  assign data_read = (state_q == S_DONE) ? rdata_q : 32'h0;
  assign ext_irq   = irq_q;

endmodule
